// File: rtl/gate_sweep_ctrl.sv
// Exhaustive sweep sequencer for a small combinational gate: drives every input vector,
// waits a settle time, samples the gate output and grades the measured truth table.
module gate_sweep_ctrl #(
    parameter int unsigned        N_IN   = 2,
    parameter int unsigned        SETTLE = 3,
    parameter logic [2**N_IN-1:0] EXPECT = 4'b1110
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                abort,
    input  logic                dut_out,
    output logic [N_IN-1:0]     dut_in,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [2**N_IN-1:0]  truth_table,
    output logic [N_IN:0]       mismatch_cnt
);

    localparam int unsigned    NVec       = 2**N_IN;
    localparam int unsigned    IdxW       = N_IN + 1;
    localparam logic [IdxW-1:0] LastIdx   = IdxW'(NVec - 1);
    localparam logic [7:0]     SettleInit = 8'(SETTLE - 1);

    typedef enum logic [2:0] {
        StIdle,
        StDrive,
        StWait,
        StSample,
        StFinish
    } state_e;

    state_e            state_q, state_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [N_IN-1:0]   dut_in_q, dut_in_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic [NVec-1:0]   table_q, table_d;
    logic [N_IN:0]     mism_q, mism_d;

    function automatic logic [N_IN:0] popcount(input logic [NVec-1:0] v);
        logic [N_IN:0] c;
        c = '0;
        for (int i = 0; i < int'(NVec); i++) begin
            c = c + (N_IN+1)'(v[i]);
        end
        return c;
    endfunction

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        dut_in_d = dut_in_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        pass_d   = pass_q;
        table_d  = table_q;
        mism_d   = mism_q;

        unique case (state_q)
            StIdle: begin
                if (start && !abort) begin
                    state_d  = StDrive;
                    idx_d    = '0;
                    table_d  = '0;
                    pass_d   = 1'b0;
                    mism_d   = '0;
                    dut_in_d = '0;
                    busy_d   = 1'b1;
                end
            end
            StDrive, StWait, StSample: begin
                if (abort) begin
                    // Partial table is kept for debug; the sweep is simply dropped.
                    state_d  = StIdle;
                    dut_in_d = '0;
                    busy_d   = 1'b0;
                    pass_d   = 1'b0;
                end else if (state_q == StDrive) begin
                    cnt_d   = SettleInit;
                    state_d = StWait;
                end else if (state_q == StWait) begin
                    if (cnt_q == 8'd0) begin
                        state_d = StSample;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end else begin
                    table_d[idx_q[N_IN-1:0]] = dut_out;
                    if (idx_q == LastIdx) begin
                        // Grade from the table including this final sample so the
                        // verdict is already valid while done is high.
                        state_d = StFinish;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = (table_d == EXPECT);
                        mism_d  = popcount(table_d ^ EXPECT);
                    end else begin
                        idx_d    = idx_q + 1'b1;
                        dut_in_d = N_IN'(idx_q + 1'b1);
                        state_d  = StDrive;
                    end
                end
            end
            StFinish: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            idx_q    <= '0;
            cnt_q    <= '0;
            dut_in_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
            table_q  <= '0;
            mism_q   <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            dut_in_q <= dut_in_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            pass_q   <= pass_d;
            table_q  <= table_d;
            mism_q   <= mism_d;
        end
    end

    assign dut_in       = dut_in_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign pass         = pass_q;
    assign truth_table  = table_q;
    assign mismatch_cnt = mism_q;

endmodule
